cnn_layer_accel_ce_macc_ctrl: RTL
=================================

CNN_LAYER_ACCEL_CE_MACC_CTRL -- requirements
Module: cnn_layer_accel_ce_macc_ctrl

Interface
REQ-001 SHALL have parameters: C_A_INPUT_WIDTH, 30, A operand width; C_B_INPUT_WIDTH, 18, B operand width; C_P_OUTPUT_WIDTH, 48, accumulator/result width; C_CNT_WIDTH, 16, term-count width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid / in_ready  in / out  1 / 1  operand-pair handshake.
- in_a / in_b  in  C_A_INPUT_WIDTH / C_B_INPUT_WIDTH  signed operands.
- in_last  in  1  marks the final term of a dot product.
- macc_a / macc_b  out  C_A_INPUT_WIDTH / C_B_INPUT_WIDTH  DSP A/B inputs.
- macc_opmode  out  9  DSP OPMODE.
- macc_alumode  out  4  DSP ALUMODE, constant 4'b0000.
- macc_ce  out  1  DSP global clock enable.
- macc_rst  out  1  active-high DSP reset.
- macc_p  in  C_P_OUTPUT_WIDTH  DSP P output.
- res_valid / res_ready  out / in  1 / 1  result handshake.
- res_data  out  C_P_OUTPUT_WIDTH  signed dot-product result.
- res_count  out  C_CNT_WIDTH  number of terms in the result.

Function
REQ-003 SHALL drive the DSP with the following pipeline timing: AREG=BREG=2, MREG=1, PREG=1, OPMODEREG=1. An operand issued in cycle t appears in P after the edge ending cycle t+3.
REQ-004 SHALL delay macc_opmode by exactly 2 enabled cycles relative to the macc_a/macc_b it belongs to, so that OPMODEREG aligns with MREG.
REQ-005 SHALL select opmode per term.
- First term of a vector: 9'b000000101 (P=A*B).
- Other terms and bubbles: 9'b000100101 (P=P+A*B).
REQ-006 SHALL hold FSM states FIRST and ACCUM.
- FIRST->ACCUM on an accepted term with in_last=0.
- Any state->FIRST on an accepted term with in_last=1.
- A single-term vector stays in FIRST.
REQ-007 SHALL accept a term when in_valid&&in_ready, and SHALL set in_ready=macc_ce.
REQ-008 SHALL issue a bubble (macc_a=0, macc_b=0, accumulate opmode, tag invalid) in every enabled cycle without an accepted term; bubbles SHALL NOT alter the sum.
REQ-009 SHALL carry a 4-stage tag pipe {valid,last,count} that advances only when macc_ce=1.
REQ-010 SHALL capture res_data<=macc_p and res_count<=tag count at the enabled edge after stage 4 holds valid&&last.
- That edge sets res_valid=1.
- Latency from acceptance of the last term to res_valid is 5 cycles.
REQ-011 SHALL drive macc_ce=!(res_valid&&!res_ready), freezing the DSP pipeline and tag pipe together.
REQ-012 SHALL clear res_valid on res_valid&&res_ready unless a new capture occurs on the same edge, in which case res_valid stays 1 and the data updates.
REQ-013 SHALL count terms in a per-vector counter.
- The counter is reset to 1 on a first term and saturates at all-ones.
- Count overflow SHALL NOT affect the sum.
REQ-014 SHALL NOT detect or flag accumulator overflow; the sum wraps at C_P_OUTPUT_WIDTH.

Reset
REQ-015 While rst_n=0, the following outputs SHALL be 0: in_ready, macc_a, macc_b, macc_opmode, macc_alumode, res_valid, res_data, res_count.
- macc_ce SHALL be 1.
- macc_rst SHALL be 1.
- The FSM SHALL be in FIRST and the tag pipe SHALL be all-invalid.
REQ-016 SHALL deassert macc_rst synchronously, 2 CLK edges after rst_n rises, and SHALL hold in_ready=0 until macc_rst is 0.
REQ-017 A reset mid-vector SHALL discard partial sums; the first vector after reset SHALL produce a correct result.

Structure
REQ-018 SHALL place the OPMODE constants (OPM_LOAD, OPM_ACCUM), ALUMODE_ADD, pipeline-latency constants and the tag struct typedef in the shared accelerator package.
REQ-019 SHALL use one sub-module, cnn_layer_accel_ce_macc_ctrl_rst_sync, for macc_rst generation; the tag pipe and FSM stay inline.

Verification
REQ-020 Single term a=3, b=-4, last=1 -> res_data=-12, res_count=1, 5 cycles after acceptance.
REQ-021 Back-to-back terms (1,2),(3,4),(5,6),(7,8 last), then immediately (2,2),(3,3 last) -> results 100 (count 4) then 13 (count 2), no stalls.
REQ-022 Same 4-term vector with in_valid gaps of 0-3 cycles between terms -> 100, count 4.
REQ-023 res_ready=0 for 10 cycles while a second result is in flight -> macc_ce=0 and in_ready=0 during the stall; both results are delivered in order and unchanged.
REQ-024 rst_n pulsed low mid-vector after 2 terms, then vector (-5,1 last) -> no spurious result; res_data=-5; macc_rst drops 2 edges after rst_n rises.
REQ-025 a=-2^29, b=-2^17, last=1 -> res_data=2^46.

Source files
------------

// File: rtl/cnn_layer_accel_ce_macc_ctrl_pkg.sv
// Shared constants and types for the CNN layer accelerator MACC controller.
// Holds DSP OPMODE/ALUMODE encodings, the DSP pipeline depths the controller
// is built around, the FSM state type and the tag carried alongside each
// operand pair.
package cnn_layer_accel_ce_macc_ctrl_pkg;

  // P = A*B (X=M, Y=M, Z=0)
  localparam logic [8:0] OPM_LOAD    = 9'b000000101;
  // P = P + A*B (X=M, Y=M, Z=P)
  localparam logic [8:0] OPM_ACCUM   = 9'b000100101;
  localparam logic [3:0] ALUMODE_ADD = 4'b0000;

  // DSP register configuration the controller assumes.
  localparam int unsigned AREG_LAT   = 2;
  localparam int unsigned BREG_LAT   = 2;
  localparam int unsigned MREG_LAT   = 1;
  localparam int unsigned PREG_LAT   = 1;
  // OPMODE leaves the controller this many enabled cycles after A/B so the
  // OPMODE register lines up with the M register.
  localparam int unsigned OPM_DELAY  = AREG_LAT;
  // Tag stages mirror A1, A2, M and P.
  localparam int unsigned TAG_STAGES = AREG_LAT + MREG_LAT + PREG_LAT;

  // Widest term count a tag can carry.
  localparam int unsigned TAG_CNT_W  = 32;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_ACCUM = 1'b1
  } macc_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [TAG_CNT_W-1:0] count;
  } macc_tag_t;

endpackage

// File: rtl/cnn_layer_accel_ce_macc_ctrl_rst_sync.sv
// Reset synchroniser for the DSP reset.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset in
//   rst_o  : active-high reset, asserted asynchronously, released on the
//            second rising edge after rst_ni goes high
module cnn_layer_accel_ce_macc_ctrl_rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d = {sync_q[0], 1'b0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_o = sync_q[1];

endmodule

// File: rtl/cnn_layer_accel_ce_macc_ctrl.sv
// Dot-product controller for a DSP MACC (AREG=BREG=2, MREG=1, PREG=1,
// OPMODEREG=1). Accepts signed operand pairs, issues them to the DSP with the
// right OPMODE, and returns one signed result plus term count per vector.
//   CLK, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : operand-pair handshake (in_a, in_b, in_last)
//   macc_a/macc_b/macc_opmode   : DSP operand and OPMODE drive
//   macc_alumode, macc_ce       : DSP ALUMODE (add) and global clock enable
//   macc_rst, macc_p            : DSP reset and P output
//   res_valid/res_ready         : result handshake (res_data, res_count)
module cnn_layer_accel_ce_macc_ctrl
  import cnn_layer_accel_ce_macc_ctrl_pkg::*;
#(
  parameter int unsigned C_A_INPUT_WIDTH  = 30,
  parameter int unsigned C_B_INPUT_WIDTH  = 18,
  parameter int unsigned C_P_OUTPUT_WIDTH = 48,
  parameter int unsigned C_CNT_WIDTH      = 16
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [C_A_INPUT_WIDTH-1:0]  in_a,
  input  logic [C_B_INPUT_WIDTH-1:0]  in_b,
  input  logic                        in_last,
  output logic [C_A_INPUT_WIDTH-1:0]  macc_a,
  output logic [C_B_INPUT_WIDTH-1:0]  macc_b,
  output logic [8:0]                  macc_opmode,
  output logic [3:0]                  macc_alumode,
  output logic                        macc_ce,
  output logic                        macc_rst,
  input  logic [C_P_OUTPUT_WIDTH-1:0] macc_p,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [C_P_OUTPUT_WIDTH-1:0] res_data,
  output logic [C_CNT_WIDTH-1:0]      res_count
);

  macc_state_e                 state_q;
  logic [C_CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [C_A_INPUT_WIDTH-1:0]  a_q;
  logic [C_B_INPUT_WIDTH-1:0]  b_q;
  logic [8:0]                  op0_q, op1_q, op2_q;
  macc_tag_t                   tag0_q;
  macc_tag_t                   tag_q [1:TAG_STAGES];
  logic                        res_valid_q;
  logic [C_P_OUTPUT_WIDTH-1:0] res_data_q;
  logic [C_CNT_WIDTH-1:0]      res_count_q;
  logic                        dsp_rst;
  logic                        ce;
  logic                        accept;
  logic                        capture;

  cnn_layer_accel_ce_macc_ctrl_rst_sync u_rst_sync (
    .clk_i  (CLK),
    .rst_ni (rst_n),
    .rst_o  (dsp_rst)
  );

  // A held result stalls the DSP and the tag pipe together so P stays
  // aligned with its tag.
  assign ce      = !(res_valid_q && !res_ready);
  assign accept  = in_valid && in_ready;
  assign capture = ce && tag_q[TAG_STAGES].valid && tag_q[TAG_STAGES].last;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_FIRST) begin
      cnt_d = C_CNT_WIDTH'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + C_CNT_WIDTH'(1);
    end
  end

  // FSM and issue stage. Cycles without an accepted term issue a zero
  // bubble with the accumulate opmode, which leaves P unchanged.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FIRST;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op0_q   <= '0;
      tag0_q  <= '0;
    end else if (ce) begin
      if (accept) begin
        a_q          <= in_a;
        b_q          <= in_b;
        op0_q        <= (state_q == ST_FIRST) ? OPM_LOAD : OPM_ACCUM;
        tag0_q.valid <= 1'b1;
        tag0_q.last  <= in_last;
        tag0_q.count <= TAG_CNT_W'(cnt_d);
        cnt_q        <= cnt_d;
        state_q      <= in_last ? ST_FIRST : ST_ACCUM;
      end else begin
        a_q    <= '0;
        b_q    <= '0;
        op0_q  <= OPM_ACCUM;
        tag0_q <= '0;
      end
    end
  end

  // OPMODE delay and tag pipe; tag stage 4 lines up with the P register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
      for (int unsigned i = 1; i <= TAG_STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else if (ce) begin
      op1_q    <= op0_q;
      op2_q    <= op1_q;
      tag_q[1] <= tag0_q;
      for (int unsigned i = TAG_STAGES; i > 1; i--) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= macc_p;
      res_count_q <= C_CNT_WIDTH'(tag_q[TAG_STAGES].count);
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign in_ready     = ce && !dsp_rst;
  assign macc_a       = a_q;
  assign macc_b       = b_q;
  assign macc_opmode  = op2_q;
  assign macc_alumode = ALUMODE_ADD;
  assign macc_ce      = ce;
  assign macc_rst     = dsp_rst;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_count    = res_count_q;

endmodule
